// File: rtl/soc_clkgen_sup.sv
// soc_clkgen_sup: SoC clock generator with MMCM lock supervisor.
// One MMCME2_ADV feeds up to four BUFG'd output clocks. A supervisor FSM on
// the buffered input clock holds the MMCM in reset, qualifies LOCKED over a
// stable window, retries on lock loss or timeout, and latches a fault after
// MAX_RETRIES failed attempts.
// Macros:
//   SOC_CLKGEN_LOSS_CNT_EN - adds loss_cnt[7:0], a saturating count of
//                            RUN->HOLD lock-loss events.
//   SYNTHESIS              - selects the Xilinx primitives; otherwise a small
//                            behavioural stand-in for IBUF/BUFG/MMCM is used.
module soc_clkgen_sup #(
    parameter real CLKIN_PERIOD        = 10.000,
    parameter int  DIVCLK_DIVIDE       = 2,
    parameter real CLKFBOUT_MULT_F     = 15.625,
    parameter int  NUM_CLKS            = 1,
    parameter real CLKOUT0_DIVIDE_F    = 78.125,
    parameter int  CLKOUT1_DIVIDE      = 10,
    parameter int  CLKOUT2_DIVIDE      = 10,
    parameter int  CLKOUT3_DIVIDE      = 10,
    parameter int  RST_HOLD_CYCLES     = 16,
    parameter int  LOCK_STABLE_CYCLES  = 256,
    parameter int  LOCK_TIMEOUT_CYCLES = 65536,
    parameter int  MAX_RETRIES         = 4
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                restart,
    output logic [NUM_CLKS-1:0] clk_out,
    output logic                ready,
    output logic                fault,
    output logic [2:0]          retries
`ifdef SOC_CLKGEN_LOSS_CNT_EN
    ,
    output logic [7:0]          loss_cnt
`endif
);

    // One counter width covers hold, stable and timeout counts.
    localparam int MAX_HS  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_HS > LOCK_TIMEOUT_CYCLES) ? MAX_HS : LOCK_TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    genvar gi;

    logic clk;
    logic locked_raw;
    logic mmcm_rst;
    logic rst_n;
    logic locked_s;

    logic [1:0]    rst_sync_reg;
    logic [1:0]    lock_sync_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] tmo_reg, tmo_next;
    logic [2:0]    retries_reg, retries_next;
    logic [2:0]    retries_inc;
    logic          ready_reg;
    logic          fault_reg;
    logic          mmcm_rst_reg;

`ifdef SYNTHESIS
    // Primitive clocking: pin -> IBUF -> (BUFG for FSM, MMCM CLKIN1).
    localparam int DIV1 = (NUM_CLKS > 1) ? CLKOUT1_DIVIDE : 1;
    localparam int DIV2 = (NUM_CLKS > 2) ? CLKOUT2_DIVIDE : 1;
    localparam int DIV3 = (NUM_CLKS > 3) ? CLKOUT3_DIVIDE : 1;

    logic       clk_ibuf;
    logic       clkfb_unbuf;
    logic       clkfb_buf;
    logic [3:0] clk_unbuf;

    IBUF u_ibuf (.I(clk_in), .O(clk_ibuf));
    BUFG u_bufg_in (.I(clk_ibuf), .O(clk));
    BUFG u_bufg_fb (.I(clkfb_unbuf), .O(clkfb_buf));

    MMCME2_ADV #(
        .BANDWIDTH        ("OPTIMIZED"),
        .COMPENSATION     ("ZHOLD"),
        .CLKIN1_PERIOD    (CLKIN_PERIOD),
        .DIVCLK_DIVIDE    (DIVCLK_DIVIDE),
        .CLKFBOUT_MULT_F  (CLKFBOUT_MULT_F),
        .CLKFBOUT_PHASE   (0.0),
        .CLKOUT0_DIVIDE_F (CLKOUT0_DIVIDE_F),
        .CLKOUT1_DIVIDE   (DIV1),
        .CLKOUT2_DIVIDE   (DIV2),
        .CLKOUT3_DIVIDE   (DIV3)
    ) u_mmcm (
        .CLKFBOUT     (clkfb_unbuf),  .CLKFBOUTB    (),
        .CLKOUT0      (clk_unbuf[0]), .CLKOUT0B     (),
        .CLKOUT1      (clk_unbuf[1]), .CLKOUT1B     (),
        .CLKOUT2      (clk_unbuf[2]), .CLKOUT2B     (),
        .CLKOUT3      (clk_unbuf[3]), .CLKOUT3B     (),
        .CLKOUT4      (),             .CLKOUT5      (),
        .CLKOUT6      (),
        .CLKFBIN      (clkfb_buf),
        .CLKIN1       (clk_ibuf),     .CLKIN2       (1'b0),
        .CLKINSEL     (1'b1),
        .DADDR        (7'd0),         .DCLK         (1'b0),
        .DEN          (1'b0),         .DI           (16'd0),
        .DO           (),             .DRDY         (),
        .DWE          (1'b0),
        .PSCLK        (1'b0),         .PSEN         (1'b0),
        .PSINCDEC     (1'b0),         .PSDONE       (),
        .LOCKED       (locked_raw),
        .CLKINSTOPPED (),             .CLKFBSTOPPED (),
        .PWRDWN       (1'b0),
        .RST          (mmcm_rst)
    );

    for (gi = 0; gi < NUM_CLKS; gi++) begin : g_bufg_out
        BUFG u_bufg_out (.I(clk_unbuf[gi]), .O(clk_out[gi]));
    end
`else
    // Behavioural stand-in: lock after ~1 us, outputs divided from clk_in.
    localparam int LOCK_DLY_RAW = $rtoi(1000.0 / CLKIN_PERIOD);
    localparam int LOCK_DLY     = (LOCK_DLY_RAW < 1) ? 1 : ((LOCK_DLY_RAW > 60000) ? 60000 : LOCK_DLY_RAW);

    logic [15:0] model_lock_cnt_reg;
    logic        model_locked_reg;

    assign clk = clk_in;
    assign locked_raw = model_locked_reg;

    // Stand-in lock timer, restarted whenever the MMCM is held in reset.
    always_ff @(posedge clk) begin
        if (mmcm_rst) begin
            model_lock_cnt_reg <= 16'd0;
            model_locked_reg   <= 1'b0;
        end else if (model_lock_cnt_reg == 16'(LOCK_DLY - 1)) begin
            model_locked_reg   <= 1'b1;
        end else begin
            model_lock_cnt_reg <= model_lock_cnt_reg + 16'd1;
        end
    end

    for (gi = 0; gi < NUM_CLKS; gi++) begin : g_model_clk
        localparam real ODIV = (gi == 0) ? CLKOUT0_DIVIDE_F :
                               (gi == 1) ? real'(CLKOUT1_DIVIDE) :
                               (gi == 2) ? real'(CLKOUT2_DIVIDE) : real'(CLKOUT3_DIVIDE);
        localparam int HALF_RAW = $rtoi(real'(DIVCLK_DIVIDE) * ODIV / (2.0 * CLKFBOUT_MULT_F) + 0.5);
        localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;

        logic [15:0] div_cnt_reg;
        logic        div_clk_reg;

        // Toggle every HALF input cycles while the MMCM is out of reset.
        always_ff @(posedge clk) begin
            if (mmcm_rst) begin
                div_cnt_reg <= 16'd0;
                div_clk_reg <= 1'b0;
            end else if (div_cnt_reg == 16'(HALF - 1)) begin
                div_cnt_reg <= 16'd0;
                div_clk_reg <= ~div_clk_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + 16'd1;
            end
        end

        assign clk_out[gi] = div_clk_reg;
    end
`endif

    // Reset: asynchronous assert, deassert released through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_reg <= 2'b00;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    // LOCKED is asynchronous to clk_in; double-flop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync_reg <= 2'b00;
        else        lock_sync_reg <= {lock_sync_reg[0], locked_raw};
    end
    assign locked_s = lock_sync_reg[1];

`ifdef SOC_CLKGEN_LOSS_CNT_EN
    logic [7:0] loss_reg, loss_next;
`endif

    assign retries_inc = retries_reg + 3'd1;

    // Next-state logic: restart first, then timeout ahead of lock progress.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        tmo_next     = tmo_reg;
        retries_next = retries_reg;
`ifdef SOC_CLKGEN_LOSS_CNT_EN
        loss_next    = loss_reg;
`endif
        if (restart) begin
            state_next   = S_HOLD;
            cnt_next     = '0;
            retries_next = 3'd0;
`ifdef SOC_CLKGEN_LOSS_CNT_EN
            loss_next    = 8'd0;
`endif
        end else begin
            case (state_reg)
                S_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_next   = '0;
                        tmo_next   = '0;
                        state_next = S_WAIT_LOCK;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    if (tmo_reg == TMO_LAST) begin
                        retries_next = retries_inc;
                        if (retries_inc == 3'(MAX_RETRIES)) begin
                            state_next = S_FAULT;
                        end else begin
                            state_next = S_HOLD;
                            cnt_next   = '0;
                        end
                    end else begin
                        tmo_next = tmo_reg + CW'(1);
                        if (state_reg == S_WAIT_LOCK) begin
                            if (locked_s) begin
                                state_next = S_STABLE;
                                cnt_next   = '0;
                            end
                        end else if (!locked_s) begin
                            state_next = S_WAIT_LOCK;
                            cnt_next   = '0;
                        end else if (cnt_reg == STABLE_LAST) begin
                            state_next   = S_RUN;
                            retries_next = 3'd0;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_next = S_HOLD;
                        cnt_next   = '0;
`ifdef SOC_CLKGEN_LOSS_CNT_EN
                        if (loss_reg != 8'hFF) loss_next = loss_reg + 8'd1;
`endif
                    end
                end
                S_FAULT: begin
                    state_next = S_FAULT;
                end
                default: begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs (decoded from next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_HOLD;
            cnt_reg      <= '0;
            tmo_reg      <= '0;
            retries_reg  <= 3'd0;
            ready_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            mmcm_rst_reg <= 1'b1;
`ifdef SOC_CLKGEN_LOSS_CNT_EN
            loss_reg     <= 8'd0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            tmo_reg      <= tmo_next;
            retries_reg  <= retries_next;
            ready_reg    <= (state_next == S_RUN);
            fault_reg    <= (state_next == S_FAULT);
            mmcm_rst_reg <= (state_next == S_HOLD) || (state_next == S_FAULT);
`ifdef SOC_CLKGEN_LOSS_CNT_EN
            loss_reg     <= loss_next;
`endif
        end
    end

    assign mmcm_rst = mmcm_rst_reg;
    assign ready    = ready_reg;
    assign fault    = fault_reg;
    assign retries  = retries_reg;
`ifdef SOC_CLKGEN_LOSS_CNT_EN
    assign loss_cnt = loss_reg;
`endif

endmodule

// File: doc/soc_clkgen_sup.md
Name: soc_clkgen_sup

Overview:
- Next-generation SoC clock generator: one MMCME2_ADV driving up to 4 parametrised output clocks, each on its own BUFG.
- Adds a lock supervisor FSM in the input-clock domain:
  - holds the MMCM in reset for a programmed time;
  - qualifies LOCKED over a stable window;
  - restarts the MMCM on lock loss or lock timeout;
  - raises a sticky fault after a bounded number of retries.
- Sits at the top of the SoC, between the board oscillator pin and all derived clock domains; `ready` gates the SoC-wide reset.

Parameters:
- CLKIN_PERIOD, 10.000, input clock period in ns (passed to MMCM).
- DIVCLK_DIVIDE, 2, MMCM input divider.
- CLKFBOUT_MULT_F, 15.625, MMCM feedback multiplier.
- NUM_CLKS, 1, number of output clocks (1..4).
- CLKOUT0_DIVIDE_F, 78.125, fractional divide for clk_out[0].
- CLKOUT1_DIVIDE, 10, integer divide for clk_out[1] (used only if NUM_CLKS>1).
- CLKOUT2_DIVIDE, 10, integer divide for clk_out[2] (used only if NUM_CLKS>2).
- CLKOUT3_DIVIDE, 10, integer divide for clk_out[3] (used only if NUM_CLKS>3).
- RST_HOLD_CYCLES, 16, clk_in cycles the MMCM RST is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 256, consecutive LOCKED-high cycles required before `ready`.
- LOCK_TIMEOUT_CYCLES, 65536, cycles allowed from RST release to qualified lock.
- MAX_RETRIES, 4, failed attempts before FAULT (1..7).

Ports:
- clk_in  input  1  board reference clock; passes through IBUF, then BUFG for the FSM.
- reset  input  1  asynchronous, active-low. Assert is asynchronous; deassert is synchronised by 2 flops on buffered clk_in.
- restart  input  1  single-cycle pulse in clk_in domain; forces a new lock sequence and clears retries/fault.
- clk_out  output  NUM_CLKS  BUFG'd MMCM outputs CLKOUT0..CLKOUT(NUM_CLKS-1).
- ready  output  1  high only in RUN state (clk_in domain, registered).
- fault  output  1  high only in FAULT state (registered).
- retries  output  3  failed-attempt count for the current sequence.

Behaviour:
- Reset (reset=0): FSM=HOLD, counters=0, retries=0, ready=0, fault=0, MMCM RST=1.
- MMCM RST is registered; it is 1 in HOLD and FAULT, 0 otherwise.
- The MMCM LOCKED output is double-flopped into clk_in domain as locked_s (2-cycle latency). The raw internal net is named locked_raw.
- FSM states and transitions (all registered, clk_in rising edge):
  - HOLD: cnt increments. When cnt==RST_HOLD_CYCLES-1: cnt<=0, tmo<=0, go to WAIT_LOCK.
  - WAIT_LOCK: tmo increments. locked_s=1 -> STABLE, cnt<=0.
  - STABLE: tmo and cnt increment while locked_s=1. locked_s=0 -> WAIT_LOCK, cnt<=0, tmo keeps running. cnt==LOCK_STABLE_CYCLES-1 -> RUN, retries<=0.
  - Timeout (WAIT_LOCK or STABLE, tmo==LOCK_TIMEOUT_CYCLES-1):
    - retries<=retries+1;
    - if retries+1==MAX_RETRIES -> FAULT;
    - else -> HOLD, cnt<=0.
    - Timeout takes priority over reaching RUN on the same cycle.
  - RUN: ready=1. locked_s=0 -> HOLD, cnt<=0, retries unchanged (0). Lock loss in RUN is not counted as a failed attempt.
  - FAULT: sticky; MMCM held in reset. Exits only via reset or restart.
- restart=1 in any state -> HOLD next cycle, cnt<=0, retries<=0; ready and fault drop on that edge. restart has priority over all other transitions.
- Counter widths: $clog2(max(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)+1). No wrap is reachable, because every compare terminates its count.
- Asynchronous reset mid-sequence: immediate return to reset values. MMCM RST goes high asynchronously with it.
- ready falls no later than 3 clk_in cycles after locked_raw falls (2 sync + 1 state register).
- Unused MMCM outputs are left open. Unused CLKOUTn divides are set to 1 and not buffered.
- DRP and phase-shift ports are tied off. CLKINSEL=1. Compensation ZHOLD. Feedback goes through BUFG.

Optional Feature:
- Macro: SOC_CLKGEN_LOSS_CNT_EN
- Defined: adds output loss_cnt [7:0], an 8-bit counter of RUN->HOLD lock-loss events.
  - Saturates at 255.
  - Cleared by reset and by restart.
  - Increments on the same edge as the RUN->HOLD transition.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Release reset with the MMCM sim model (RST_HOLD_CYCLES=16, LOCK_STABLE_CYCLES=256) -> MMCM RST=1 for exactly 16 cycles; then ready=1, fault=0, retries=0 once locked_s has been high 256 cycles; clk_out[0] = 100*15.625/(2*78.125) = 10 MHz.
- Force locked_raw=0 for 1 cycle during STABLE at cnt=100 -> return to WAIT_LOCK; ready rises only after 256 fresh consecutive locked cycles; retries stays 0.
- Force locked_raw=0 permanently with LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=3 -> retries steps 1, 2; then fault=1 with retries=3, MMCM RST stays 1; a restart pulse -> HOLD, retries=0, fault=0.
- In RUN, force locked_raw=0 -> ready=0 within 3 cycles, MMCM RST=1 for 16 cycles, relock reaches RUN; with SOC_CLKGEN_LOSS_CNT_EN, loss_cnt=1.
- Assert reset in STABLE mid-count and deassert after 5 cycles -> all outputs at reset values during reset; full HOLD sequence restarts 2 cycles after deassert.
- Pulse restart on the same cycle as a timeout -> restart wins: HOLD, retries=0, fault never asserts.
